// File: rtl/alu6_result_fifo.sv
// alu6_result_fifo: small result queue behind the 6-bit bitwise units.
// Each entry holds the producer opcode tag, the 6-bit result and the
// zero/ones flags, which are computed once at push time.
// Optional build macro: ALU6_RESULT_PARITY_EN adds the out_par port and a
// stored even-parity bit per entry.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready
// are both high on that side. in_ready depends only on registered count,
// so it never combinationally follows out_ready. Head data is driven while
// out_valid is high, stays stable until popped, and reads 0 otherwise.
module alu6_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [2:0]                 in_op,
  input  logic [5:0]                 in_res,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_op,
  output logic [5:0]                 out_res,
  output logic                       out_zero,
  output logic                       out_ones,
`ifdef ALU6_RESULT_PARITY_EN
  output logic                       out_par,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [2:0]    op_mem   [DEPTH];
  logic [5:0]    res_mem  [DEPTH];
  logic          zero_mem [DEPTH];
  logic          ones_mem [DEPTH];
`ifdef ALU6_RESULT_PARITY_EN
  logic          par_mem  [DEPTH];
`endif

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; not reset, stale contents are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= in_op;
      res_mem[wr_ptr]  <= in_res;
      zero_mem[wr_ptr] <= (in_res == 6'h00);
      ones_mem[wr_ptr] <= (in_res == 6'h3F);
`ifdef ALU6_RESULT_PARITY_EN
      par_mem[wr_ptr]  <= ^in_res;
`endif
    end
  end

  // Head presentation, forced to 0 when the queue is empty.
  always_comb begin
    out_op   = '0;
    out_res  = '0;
    out_zero = 1'b0;
    out_ones = 1'b0;
`ifdef ALU6_RESULT_PARITY_EN
    out_par  = 1'b0;
`endif
    if (out_valid) begin
      out_op   = op_mem[rd_ptr];
      out_res  = res_mem[rd_ptr];
      out_zero = zero_mem[rd_ptr];
      out_ones = ones_mem[rd_ptr];
`ifdef ALU6_RESULT_PARITY_EN
      out_par  = par_mem[rd_ptr];
`endif
    end
  end

endmodule

// File: tb/tb_alu6_result_fifo.sv
// Directed bench for alu6_result_fifo (DEPTH = 4).
module tb_alu6_result_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_op;
  logic [5:0] in_res;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_op;
  logic [5:0] out_res;
  logic       out_zero;
  logic       out_ones;
`ifdef ALU6_RESULT_PARITY_EN
  logic       out_par;
`endif
  logic [2:0] count;

  int n_checks;
  int n_pass;

  // expected entries as {op, res}
  logic [8:0] exp_q[$];

  alu6_result_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_op     (in_op),
    .in_res    (in_res),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
`ifdef ALU6_RESULT_PARITY_EN
    .out_par   (out_par),
`endif
    .count     (count)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // drive one accepted push for a cycle (inputs change on negedge)
  task automatic push_one(input logic [2:0] op, input logic [5:0] res);
    in_valid = 1'b1;
    in_op    = op;
    in_res   = res;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back({op, res});
  endtask

  // check head against scoreboard, then pop it
  task automatic pop_one();
    logic [8:0] e;
    e = exp_q.pop_front();
    check("head_valid", 32'(out_valid), 32'd1);
    check("head_op",    32'(out_op),    32'(e[8:6]));
    check("head_res",   32'(out_res),   32'(e[5:0]));
    check("head_zero",  32'(out_zero),  32'(e[5:0] == 6'h00));
    check("head_ones",  32'(out_ones),  32'(e[5:0] == 6'h3F));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 32) begin
      pop_one();
      guard++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_res    = '0;
    out_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res",   32'(out_res),   32'd0);
    rst_n = 1'b1;

    // single push of zero result: visible one cycle later
    in_valid = 1'b1; in_op = 3'd1; in_res = 6'h00;
    check("no_bypass", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back({3'd1, 6'h00});
    check("p1_count", 32'(count), 32'd1);
    pop_one();
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_res",   32'(out_res),   32'd0);
    check("empty_zero",  32'(out_zero),  32'd0);

    // pop attempt on empty must not underflow
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("underflow_count", 32'(count), 32'd0);

    // fill to DEPTH, overflow attempt ignored, drain in order
    push_one(3'd2, 6'h01);
    push_one(3'd3, 6'h02);
    push_one(3'd4, 6'h03);
    push_one(3'd5, 6'h04);
    check("full_count", 32'(count),    32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_op = 3'd7; in_res = 6'h3E;
    @(negedge clk);
    in_valid = 1'b0;
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_head",  32'(out_res), 32'h01);
    drain();
    check("drained_count", 32'(count), 32'd0);

    // simultaneous push and pop with two entries stored
    push_one(3'd2, 6'h2A);
    push_one(3'd3, 6'h11);
    check("pp_pre_count", 32'(count), 32'd2);
    check("pp_pre_head",  32'(out_res), 32'h2A);
    in_valid = 1'b1; in_op = 3'd5; in_res = 6'h3F;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({3'd5, 6'h3F});
    check("pp_count", 32'(count), 32'd2);
    check("pp_head",  32'(out_res), 32'h11);
    // head holds while not popped
    @(negedge clk);
    check("hold_res", 32'(out_res), 32'h11);
    check("hold_op",  32'(out_op),  32'd3);
    drain();

    // full, one pop frees a slot, new entry wraps and follows the older three
    push_one(3'd1, 6'h05);
    push_one(3'd1, 6'h06);
    push_one(3'd1, 6'h07);
    push_one(3'd1, 6'h08);
    check("wrap_full_ready", 32'(in_ready), 32'd0);
    pop_one();
    check("wrap_ready", 32'(in_ready), 32'd1);
    check("wrap_count", 32'(count),    32'd3);
    push_one(3'd6, 6'h15);
    check("wrap_count4", 32'(count), 32'd4);
    drain();

`ifdef ALU6_RESULT_PARITY_EN
    push_one(3'd0, 6'h07);
    push_one(3'd0, 6'h03);
    check("par_07", 32'(out_par), 32'd1);
    pop_one();
    check("par_03", 32'(out_par), 32'd0);
    pop_one();
    check("par_empty", 32'(out_par), 32'd0);
`endif

    // asynchronous reset mid-cycle with three entries stored
    push_one(3'd2, 6'h21);
    push_one(3'd2, 6'h22);
    push_one(3'd2, 6'h23);
    check("pre_rst_count", 32'(count), 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count",    32'(count),     32'd0);
    check("arst_valid",    32'(out_valid), 32'd0);
    check("arst_res",      32'(out_res),   32'd0);
    check("arst_op",       32'(out_op),    32'd0);
    check("arst_in_ready", 32'(in_ready),  32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset accepts a push
    push_one(3'd4, 6'h2C);
    check("post_rst_count", 32'(count), 32'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time limit
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu6_result_fifo.md
ALU6_RESULT_FIFO -- requirements
Module: alu6_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4: number of result entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream 6-bit bitwise unit (XNOR6 and siblings) presents a result.
REQ-005 in_op  input  3  opcode tag of the unit that produced in_res.
REQ-006 in_res  input  6  6-bit bitwise result.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 out_valid  output  1  head entry present on out_* ports.
REQ-009 out_ready  input  1  downstream accepts head entry.
REQ-010 out_op  output  3  tag of head entry.
REQ-011 out_res  output  6  result of head entry.
REQ-012 out_zero  output  1  head result == 6'h00.
REQ-013 out_ones  output  1  head result == 6'h3F.
REQ-014 count  output  log2(DEPTH)+1  number of stored entries.

Function
REQ-015 Push SHALL occur on a rising edge when in_valid && in_ready; pop when out_valid && out_ready.
REQ-016 in_ready SHALL be (count < DEPTH), derived from registered state only, never from out_ready.
REQ-017 out_valid SHALL be (count != 0); no empty-to-output bypass: a push into an empty FIFO makes out_valid 1 on the following cycle (latency 1).
REQ-018 zero/ones flags SHALL be computed from in_res at push time and stored with the entry.
REQ-019 Entries SHALL leave in push order; write and read pointers wrap modulo DEPTH.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged.
REQ-021 When full, in_ready = 0; a pop that cycle frees a slot, in_ready = 1 next cycle.
REQ-022 When empty, out_ready is ignored; count never underflows or exceeds DEPTH.
REQ-023 While out_valid && !out_ready, out_op/out_res/out_zero/out_ones SHALL hold stable.
REQ-024 in_valid while !in_ready SHALL have no effect; upstream holds data.
REQ-025 out_* data ports SHALL be 0 when out_valid = 0.

Reset
REQ-026 rst_n low SHALL immediately clear count, both pointers, out_valid, out_res, out_op, out_zero, out_ones (and out_par) to 0; in_ready reads 1.
REQ-027 Reset mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-028 First push accepted on the first rising edge with rst_n high.

Configuration
REQ-029 Macro ALU6_RESULT_PARITY_EN defined: extra output out_par (1 bit) = XOR of the head's 6 result bits, computed at push and stored like the other flags; 0 when out_valid = 0.
REQ-030 Macro undefined: out_par port and its storage SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, push in_res=6'h00 op=3'd1 -> next cycle out_valid=1, out_res=6'h00, out_zero=1, out_ones=0, count=1.
REQ-032 DEPTH=4, out_ready=0, push 6'h01,6'h02,6'h03,6'h04 -> count=4, in_ready=0; 5th in_valid ignored; drain -> 01,02,03,04 in order.
REQ-033 count=2, push 6'h3F and pop same edge -> count stays 2, stored entry has out_ones=1.
REQ-034 Full, one pop -> in_ready=1 next cycle; push 6'h15 -> reaches head after the 3 older entries, pointer wrap verified.
REQ-035 count=3, assert rst_n=0 mid-cycle -> count=0, out_valid=0, out_res=0 immediately, before next clk edge.
REQ-036 With ALU6_RESULT_PARITY_EN, push 6'h07 -> out_par=1; push 6'h03 -> out_par=0.
